// File: rtl/apb_slave_mem_if.sv
// APB3/APB4 completer bus bundle: request signals from the master, response from the completer.
interface apb_slave_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   PADDR;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [DATA_W-1:0]   PWDATA;
  logic [2:0]          PPROT;
  logic [DATA_W/8-1:0] PSTRB;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with optional wait states,
// byte-strobe writes and SLVERR for out-of-range, misaligned or privilege-violating accesses.
module apb_slave_mem #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_CYCLES = 0,
  parameter bit              APB4        = 1'b1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_slave_mem_if.slave    apb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [IDX_W-1:0]    r_idx;
  logic                r_write;
  logic                r_err;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [DATA_W-1:0]   r_prdata;
  logic                r_pready;
  logic                r_pslverr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_setup;
  logic                w_complete;
  logic [ADDR_W-1:0]   w_offset;
  logic [IDX_W-1:0]    w_idx;
  logic                w_below;
  logic                w_oob;
  logic                w_misal;
  logic                w_rd_strb_err;
  logic                w_priv_err;
  logic                w_err;
  logic [STRB_W-1:0]   w_strb;
  logic                w_load;
  logic [IDX_W-1:0]    w_load_idx;
  logic                w_load_err;
  logic                w_load_wr;
  logic                w_commit;
  logic [DATA_W-1:0]   w_bmask;
  logic                w_unused_prot;

  assign w_setup    = apb.PSEL && !apb.PENABLE;
  assign w_complete = apb.PSEL && apb.PENABLE;

  // Address decode and error classification, evaluated on the setup cycle only.
  assign w_offset      = apb.PADDR - BASE_ADDR;
  assign w_idx         = w_offset[LSB +: IDX_W];
  assign w_below       = apb.PADDR < BASE_ADDR;
  assign w_oob         = (w_offset >> (LSB + IDX_W)) != '0;
  assign w_misal       = (w_offset & ADDR_W'(STRB_W - 1)) != '0;
  assign w_rd_strb_err = APB4 && !apb.PWRITE && (apb.PSTRB != '0);
  assign w_priv_err    = APB4 && apb.PWRITE && (w_idx == '0) && !apb.PPROT[0];
  assign w_err         = w_below || w_oob || w_misal || w_rd_strb_err || w_priv_err;
  assign w_strb        = APB4 ? apb.PSTRB : '1;
  assign w_unused_prot = ^apb.PPROT[2:1];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = READY;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!apb.PSEL) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt <= 4'd1) begin
          w_state_next = READY;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      READY: begin
        if (!apb.PSEL || apb.PENABLE) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Response is captured on the edge that enters READY; with no wait states that is the setup edge itself.
  assign w_load     = (r_state != READY) && (w_state_next == READY);
  assign w_load_idx = (r_state == IDLE) ? w_idx         : r_idx;
  assign w_load_err = (r_state == IDLE) ? w_err         : r_err;
  assign w_load_wr  = (r_state == IDLE) ? apb.PWRITE    : r_write;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_pready <= (w_state_next == READY);
      if (r_state == IDLE && w_setup) begin
        r_idx   <= w_idx;
        r_write <= apb.PWRITE;
        r_err   <= w_err;
        r_wdata <= apb.PWDATA;
        r_strb  <= w_strb;
      end
      if (w_load) begin
        r_prdata  <= (w_load_err || w_load_wr) ? '0 : r_mem[w_load_idx];
        r_pslverr <= w_load_err;
      end else if (w_state_next != READY) begin
        r_prdata  <= '0;
        r_pslverr <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_bmask
      assign w_bmask[gi*8 +: 8] = {8{r_strb[gi]}};
    end
  endgenerate

  assign w_commit = (r_state == READY) && w_complete && r_write && !r_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= (r_mem[r_idx] & ~w_bmask) | (r_wdata & w_bmask);
    end
  end

  assign apb.PRDATA  = r_prdata;
  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three configurations share one driver and an expectation queue.
module tb_apb_slave_mem;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  t_sel;
  logic [31:0] t_paddr;
  logic        t_psel;
  logic        t_penable;
  logic        t_pwrite;
  logic [31:0] t_pwdata;
  logic [2:0]  t_pprot;
  logic [3:0]  t_pstrb;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  int n_checks = 0;
  int n_errors = 0;
  time t_prev = 0;
  time t_cur  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

  assign if0.PADDR = t_paddr;  assign if1.PADDR = t_paddr;  assign if2.PADDR = t_paddr;
  assign if0.PENABLE = t_penable;  assign if1.PENABLE = t_penable;  assign if2.PENABLE = t_penable;
  assign if0.PWRITE = t_pwrite;  assign if1.PWRITE = t_pwrite;  assign if2.PWRITE = t_pwrite;
  assign if0.PWDATA = t_pwdata;  assign if1.PWDATA = t_pwdata;  assign if2.PWDATA = t_pwdata;
  assign if0.PPROT = t_pprot;  assign if1.PPROT = t_pprot;  assign if2.PPROT = t_pprot;
  assign if0.PSTRB = t_pstrb;  assign if1.PSTRB = t_pstrb;  assign if2.PSTRB = t_pstrb;
  assign if0.PSEL = t_psel && (t_sel == 2'd0);
  assign if1.PSEL = t_psel && (t_sel == 2'd1);
  assign if2.PSEL = t_psel && (t_sel == 2'd2);

  apb_slave_mem #(.WAIT_CYCLES(0), .APB4(1'b1)) u_w0 (.PCLK(PCLK), .PRESET(PRESET), .apb(if0));
  apb_slave_mem #(.WAIT_CYCLES(3), .APB4(1'b1)) u_w3 (.PCLK(PCLK), .PRESET(PRESET), .apb(if1));
  apb_slave_mem #(.WAIT_CYCLES(0), .APB4(1'b0)) u_a3 (.PCLK(PCLK), .PRESET(PRESET), .apb(if2));

  always_comb begin
    m_prdata  = if0.PRDATA;
    m_pready  = if0.PREADY;
    m_pslverr = if0.PSLVERR;
    case (t_sel)
      2'd1: begin m_prdata = if1.PRDATA; m_pready = if1.PREADY; m_pslverr = if1.PSLVERR; end
      2'd2: begin m_prdata = if2.PRDATA; m_pready = if2.PREADY; m_pslverr = if2.PSLVERR; end
      default: ;
    endcase
  end

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one transfer starting now; returns one cycle after completion with the bus idle.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_wait);
    int   n;
    exp_t e;
    t_prev    = t_cur;
    t_cur     = $time;
    t_psel    = 1'b1;
    t_penable = 1'b0;
    t_pwrite  = wr;
    t_paddr   = addr;
    t_pwdata  = wdata;
    t_pstrb   = strb;
    t_pprot   = prot;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge PCLK); #1;
    t_penable = 1'b1;
    n = 0;
    while (!m_pready && n < 40) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
    e = sb.pop_front();
    chk({tag, "_rdata"}, m_prdata, e.rdata);
    chk({tag, "_slverr"}, 32'(m_pslverr), 32'(e.err));
    $display("xfer %s wr=%0b addr=0x%08h wdata=0x%08h strb=%h prot=%0d rdata=0x%08h slverr=%0b wait=%0d",
             tag, wr, addr, wdata, strb, prot, m_prdata, m_pslverr, n);
    @(posedge PCLK); #1;
    t_psel    = 1'b0;
    t_penable = 1'b0;
    chk({tag, "_post_pready"}, 32'(m_pready), 32'd0);
    chk({tag, "_post_prdata"}, m_prdata, 32'd0);
  endtask

  initial begin
    int hi;
    t_sel = 2'd0; t_paddr = '0; t_psel = 1'b0; t_penable = 1'b0;
    t_pwrite = 1'b0; t_pwdata = '0; t_pprot = '0; t_pstrb = '0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      t_sel = 2'(k); #1;
      chk($sformatf("reset_pready_%0d", k), 32'(m_pready), 32'd0);
      chk($sformatf("reset_prdata_%0d", k), m_prdata, 32'd0);
      chk($sformatf("reset_pslverr_%0d", k), 32'(m_pslverr), 32'd0);
    end
    PRESET = 1'b0;
    t_sel = 2'd0;
    @(posedge PCLK); #1;

    // Cleared memory, no wait states
    for (int i = 0; i < 16; i++)
      xfer($sformatf("rd0_w%0d", i), 1'b0, 32'(i * 4), '0, 4'h0, 3'd0, 32'h0, 1'b0, 0);

    // Byte-strobe merge
    xfer("wr_w3_full", 1'b1, 32'd12, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0, 1'b0, 0);
    xfer("wr_w3_strb5", 1'b1, 32'd12, 32'h11223344, 4'h5, 3'd0, 32'h0, 1'b0, 0);
    xfer("rd_w3_merged", 1'b0, 32'd12, '0, 4'h0, 3'd0, 32'hDE22BE44, 1'b0, 0);

    // Error responses
    xfer("err_oob", 1'b0, 32'd64, '0, 4'h0, 3'd0, 32'h0, 1'b1, 0);
    xfer("ok_last_word", 1'b0, 32'd60, '0, 4'h0, 3'd0, 32'h0, 1'b0, 0);
    xfer("err_misal", 1'b0, 32'd2, '0, 4'h0, 3'd0, 32'h0, 1'b1, 0);
    xfer("err_priv_w0", 1'b1, 32'd0, 32'hCAFEF00D, 4'hF, 3'd0, 32'h0, 1'b1, 0);
    xfer("rd_w0_unchanged", 1'b0, 32'd0, '0, 4'h0, 3'd0, 32'h0, 1'b0, 0);
    xfer("wr_w0_priv", 1'b1, 32'd0, 32'h01020304, 4'hF, 3'd1, 32'h0, 1'b0, 0);
    xfer("rd_w0_priv", 1'b0, 32'd0, '0, 4'h0, 3'd0, 32'h01020304, 1'b0, 0);
    xfer("err_rd_strb", 1'b0, 32'd12, '0, 4'h1, 3'd0, 32'h0, 1'b1, 0);

    // PENABLE without a setup phase is ignored
    t_psel = 1'b1; t_penable = 1'b1; t_paddr = 32'd12; t_pwrite = 1'b0; t_pstrb = 4'h0;
    hi = 0;
    repeat (3) begin
      @(posedge PCLK); #1;
      if (m_pready) hi++;
    end
    chk("idle_penable_no_pready", 32'(hi), 32'd0);
    t_psel = 1'b0; t_penable = 1'b0;
    @(posedge PCLK); #1;

    // Three wait states, back-to-back
    t_sel = 2'd1;
    xfer("w3_wr_w1", 1'b1, 32'd4, 32'hA5A5A5A5, 4'hF, 3'd0, 32'h0, 1'b0, 3);
    xfer("w3_wr_w2", 1'b1, 32'd8, 32'h5A5A5A5A, 4'hF, 3'd0, 32'h0, 1'b0, 3);
    chk("w3_b2b_period_1", 32'(t_cur - t_prev), 32'd50);
    xfer("w3_rd_w1", 1'b0, 32'd4, '0, 4'h0, 3'd0, 32'hA5A5A5A5, 1'b0, 3);
    chk("w3_b2b_period_2", 32'(t_cur - t_prev), 32'd50);
    xfer("w3_rd_w2", 1'b0, 32'd8, '0, 4'h0, 3'd0, 32'h5A5A5A5A, 1'b0, 3);
    chk("w3_b2b_period_3", 32'(t_cur - t_prev), 32'd50);

    // APB3 mode: strobes forced on, PPROT ignored
    t_sel = 2'd2;
    @(posedge PCLK); #1;
    xfer("a3_wr_w5", 1'b1, 32'd20, 32'h12345678, 4'h0, 3'd0, 32'h0, 1'b0, 0);
    xfer("a3_rd_w5", 1'b0, 32'd20, '0, 4'h0, 3'd0, 32'h12345678, 1'b0, 0);
    xfer("a3_wr_w0", 1'b1, 32'd0, 32'h00000055, 4'h0, 3'd0, 32'h0, 1'b0, 0);
    xfer("a3_rd_w0_strb", 1'b0, 32'd0, '0, 4'h1, 3'd0, 32'h00000055, 1'b0, 0);

    // Reset in the middle of a wait-state write
    t_sel = 2'd1;
    t_psel = 1'b1; t_penable = 1'b0; t_pwrite = 1'b1; t_paddr = 32'd8;
    t_pwdata = 32'h99999999; t_pstrb = 4'hF; t_pprot = 3'd0;
    @(posedge PCLK); #1;
    t_penable = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_mid_pready_before", 32'(m_pready), 32'd0);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_mid_pready", 32'(m_pready), 32'd0);
    chk("rst_mid_prdata", m_prdata, 32'd0);
    chk("rst_mid_pslverr", 32'(m_pslverr), 32'd0);
    PRESET = 1'b0; t_psel = 1'b0; t_penable = 1'b0;
    @(posedge PCLK); #1;
    xfer("rst_rd_w2", 1'b0, 32'd8, '0, 4'h0, 3'd0, 32'h0, 1'b0, 3);
    xfer("rst_wr_w2", 1'b1, 32'd8, 32'h0BADCAFE, 4'hF, 3'd0, 32'h0, 1'b0, 3);
    xfer("rst_rd_w2b", 1'b0, 32'd8, '0, 4'h0, 3'd0, 32'h0BADCAFE, 1'b0, 3);

    // Master drops PSEL during wait states
    t_psel = 1'b1; t_penable = 1'b0; t_pwrite = 1'b1; t_paddr = 32'd16;
    t_pwdata = 32'h00000077; t_pstrb = 4'hF; t_pprot = 3'd1;
    @(posedge PCLK); #1;
    t_penable = 1'b1;
    @(posedge PCLK); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    hi = 0;
    repeat (6) begin
      @(posedge PCLK); #1;
      if (m_pready) hi++;
    end
    chk("abort_no_pready", 32'(hi), 32'd0);
    xfer("abort_rd_w4", 1'b0, 32'd16, '0, 4'h0, 3'd0, 32'h0, 1'b0, 3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
